// File: rtl/core_sequencer_if.sv
// Sequencer-side bundle: run control, fetch port, decoder sample, ALU handshake, write-back, status.
// The sequencer owns the master modport; memory/decoder/ALU/GPR side uses slave.
interface core_sequencer_if;
  logic        i_run;
  logic        o_fetch_req;
  logic [63:0] o_fetch_addr;
  logic        i_fetch_ack;
  logic [31:0] i_fetch_data;
  logic [31:0] o_insn;
  logic        i_dec_valid;
  logic [3:0]  i_dec_to_state;
  logic [63:0] i_dec_src1;
  logic [4:0]  i_dec_dst;
  logic        o_alu_start;
  logic        i_alu_done;
  logic [63:0] i_alu_result;
  logic        o_wb_en;
  logic [4:0]  o_wb_addr;
  logic [63:0] o_wb_data;
  logic [63:0] o_pc;
  logic [3:0]  o_state;
  logic        o_halted;
  logic        o_trap;
  logic [1:0]  o_trap_cause;

  modport master (
    input  i_run, i_fetch_ack, i_fetch_data, i_dec_valid, i_dec_to_state, i_dec_src1,
           i_dec_dst, i_alu_done, i_alu_result,
    output o_fetch_req, o_fetch_addr, o_insn, o_alu_start, o_wb_en, o_wb_addr, o_wb_data,
           o_pc, o_state, o_halted, o_trap, o_trap_cause
  );

  modport slave (
    output i_run, i_fetch_ack, i_fetch_data, i_dec_valid, i_dec_to_state, i_dec_src1,
           i_dec_dst, i_alu_done, i_alu_result,
    input  o_fetch_req, o_fetch_addr, o_insn, o_alu_start, o_wb_en, o_wb_addr, o_wb_data,
           o_pc, o_state, o_halted, o_trap, o_trap_cause
  );
endinterface

// File: rtl/core_sequencer.sv
// Core control FSM: fetch, decode sample, ALU sequencing, GPR write-back, PC advance, halt/trap.
// Optional fetch watchdog enabled by defining CORE_SEQ_FETCH_TIMEOUT_EN.
module core_sequencer #(
  parameter logic [63:0] RESET_PC      = 64'h0,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input logic              i_clk,
  input logic              i_rst_n,
  core_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StFetch     = 4'd1,
    StDecode    = 4'd2,
    StExecute   = 4'd3,
    StSrc1ToDst = 4'd4,
    StWriteback = 4'd5,
    StHalt      = 4'd6,
    StTrap      = 4'd7
  } state_e;

  localparam logic [1:0] CauseInvalid = 2'b01;
  localparam logic [1:0] CauseUnsup   = 2'b10;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] insn_q, insn_d;
  logic [4:0]  dst_q, dst_d;
  logic        fetch_req_q, fetch_req_d;
  logic        alu_start_q, alu_start_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic        halted_q, halted_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;

`ifdef CORE_SEQ_FETCH_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(FETCH_TIMEOUT + 1) > 8) ? $clog2(FETCH_TIMEOUT + 1) : 8;
  localparam logic [CntW-1:0] TimeoutLast  = CntW'(FETCH_TIMEOUT - 1);
  localparam logic [1:0]      CauseTimeout = 2'b11;
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic unused_fetch_timeout;
  assign unused_fetch_timeout = ^FETCH_TIMEOUT;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    insn_d    = insn_q;
    dst_d     = dst_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    cause_d   = cause_q;
`ifdef CORE_SEQ_FETCH_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.i_run) state_d = StFetch;
      end
      StFetch: begin
        // An ack on the terminal watchdog cycle still wins.
        if (bus.i_fetch_ack) begin
          insn_d  = bus.i_fetch_data;
          state_d = StDecode;
        end
`ifdef CORE_SEQ_FETCH_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StDecode: begin
        if (!bus.i_dec_valid) begin
          state_d = StTrap;
          cause_d = CauseInvalid;
        end else begin
          case (bus.i_dec_to_state)
            StHalt: state_d = StHalt;
            StSrc1ToDst: begin
              wb_addr_d = bus.i_dec_dst;
              wb_data_d = bus.i_dec_src1;
              state_d   = StWriteback;
            end
            StExecute: begin
              dst_d   = bus.i_dec_dst;
              state_d = StExecute;
            end
            default: begin
              state_d = StTrap;
              cause_d = CauseUnsup;
            end
          endcase
        end
      end
      StExecute: begin
        if (bus.i_alu_done) begin
          wb_addr_d = dst_q;
          wb_data_d = bus.i_alu_result;
          state_d   = StWriteback;
        end
      end
      StWriteback: begin
        pc_d    = pc_q + 64'd4;
        state_d = bus.i_run ? StFetch : StIdle;
      end
      StHalt, StTrap: ;
      default: state_d = StIdle;
    endcase
`ifdef CORE_SEQ_FETCH_TIMEOUT_EN
    if (state_d == StFetch && state_q != StFetch) cnt_d = '0;
`endif
    // Status outputs are registered, so derive them from the state being entered.
    fetch_req_d = (state_d == StFetch);
    alu_start_d = (state_q == StDecode) && (state_d == StExecute);
    wb_en_d     = (state_d == StWriteback);
    halted_d    = (state_d == StHalt);
    trap_d      = (state_d == StTrap);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      insn_q      <= '0;
      dst_q       <= '0;
      fetch_req_q <= 1'b0;
      alu_start_q <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      halted_q    <= 1'b0;
      trap_q      <= 1'b0;
      cause_q     <= '0;
`ifdef CORE_SEQ_FETCH_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      insn_q      <= insn_d;
      dst_q       <= dst_d;
      fetch_req_q <= fetch_req_d;
      alu_start_q <= alu_start_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      halted_q    <= halted_d;
      trap_q      <= trap_d;
      cause_q     <= cause_d;
`ifdef CORE_SEQ_FETCH_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.o_fetch_req  = fetch_req_q;
  assign bus.o_fetch_addr = pc_q;
  assign bus.o_insn       = insn_q;
  assign bus.o_alu_start  = alu_start_q;
  assign bus.o_wb_en      = wb_en_q;
  assign bus.o_wb_addr    = wb_addr_q;
  assign bus.o_wb_data    = wb_data_q;
  assign bus.o_pc         = pc_q;
  assign bus.o_state      = state_q;
  assign bus.o_halted     = halted_q;
  assign bus.o_trap       = trap_q;
  assign bus.o_trap_cause = cause_q;

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Top-level control FSM for the core.
- Fetches 32-bit instructions over a req/ack port and presents each to the combinational decoder.
- Samples the decoder's valid/to_state/src1/dst, sequences ALU start/done, issues GPR write-back and advances the PC.
- Halts on the halt singleton and traps on invalid or unsupported decodes.

Parameters:
RESET_PC, 64'h0, PC value loaded at reset
FETCH_TIMEOUT, 255, FETCH cycles without ack before trap (only with CORE_SEQ_FETCH_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_run  in  1  level; enables execution
o_fetch_req  out  1  fetch request, held until ack
o_fetch_addr  out  64  fetch address (= PC)
i_fetch_ack  in  1  fetch data valid
i_fetch_data  in  32  fetched instruction
o_insn  out  32  registered instruction to decoder
i_dec_valid  in  1  decoder valid
i_dec_to_state  in  4  decoder next-state request
i_dec_src1  in  64  decoder src1 operand
i_dec_dst  in  5  decoder destination register
o_alu_start  out  1  one-cycle ALU start pulse
i_alu_done  in  1  ALU result valid
i_alu_result  in  64  ALU result
o_wb_en  out  1  GPR write enable, one cycle
o_wb_addr  out  5  GPR write index
o_wb_data  out  64  GPR write data
o_pc  out  64  current PC
o_state  out  4  current FSM state
o_halted  out  1  in HALT
o_trap  out  1  in TRAP
o_trap_cause  out  2  01 invalid, 10 unsupported to_state, 11 fetch timeout

Behaviour:
- State encoding (shared in cpustate.vinc): IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, SRC1_TO_DST=4, WRITEBACK=5, HALT=6, TRAP=7.
- Reset (async, any state, mid-fetch included): state=IDLE, PC=RESET_PC, o_insn=0, all other outputs 0. An in-flight fetch is abandoned; an ack arriving in IDLE is ignored.
- IDLE: i_run=1 -> FETCH next cycle.
- FETCH: o_fetch_req=1, o_fetch_addr=PC in every FETCH cycle.
  - On i_fetch_ack: latch i_fetch_data into o_insn, then -> DECODE.
  - o_fetch_req is 0 from the following cycle.
- DECODE: one cycle; decoder evaluates o_insn combinationally.
  - i_dec_valid=0 -> TRAP, cause 01.
  - to_state=HALT -> HALT; PC is not incremented, so o_pc points at the halt instruction.
  - to_state=SRC1_TO_DST -> WRITEBACK with wb_addr=i_dec_dst, wb_data=i_dec_src1 latched.
  - to_state=EXECUTE -> EXECUTE; latch i_dec_dst; o_alu_start=1 for exactly the first EXECUTE cycle.
  - Any other to_state -> TRAP, cause 10.
- EXECUTE: wait indefinitely for i_alu_done (a done in the same cycle as start is accepted). On done: latch i_alu_result, -> WRITEBACK.
- WRITEBACK: o_wb_en=1 for one cycle with the latched addr/data. PC <= PC+4, 64-bit wrap (FFFF_FFFF_FFFF_FFFC -> 0).
  - Next state is FETCH if i_run=1, else IDLE.
- i_run is checked only in IDLE and WRITEBACK. Deassertion mid-instruction completes the current instruction.
- HALT and TRAP are sticky until reset. o_halted / o_trap are registered, high from the first cycle in state. Cause holds until reset.
- i_fetch_ack outside FETCH and i_alu_done outside EXECUTE are ignored.
- Latency with zero-wait ack: load-immediate retires in 3 cycles (FETCH, DECODE, WRITEBACK), so back-to-back rate is 1 instruction per 3 cycles. An ALU instruction takes 4 cycles plus ALU latency.
- o_wb_addr / o_wb_data hold their last values when o_wb_en=0.

Optional Feature:
CORE_SEQ_FETCH_TIMEOUT_EN:
- Defined: an 8+-bit counter clears on FETCH entry and increments each FETCH cycle without ack. Reaching FETCH_TIMEOUT -> TRAP, cause 11, o_fetch_req dropped. An ack on the terminal cycle wins over the timeout.
- Undefined: no counter; FETCH waits forever; cause 11 is never produced.

Test Plan:
- Reset with i_run=1, zero-wait ack, decoder attached, mem[0]=32'h2030_1234 (li r3,0x1234), mem[4]=0 -> o_wb_en pulse with addr 3 / data 64'h1234 on cycle 3. PC=4, then HALT with o_halted=1, o_pc=4.
- Fetch ack delayed 5 cycles -> o_fetch_req high exactly 6 cycles, addr stable at PC, no other activity.
- mem[0]=32'h7FFF_FFFF (k=11) -> TRAP, o_trap=1, o_trap_cause=01, o_wb_en never asserted, PC=0.
- Bench-driven to_state=EXECUTE, i_alu_done after 3 cycles with result 64'hDEAD_BEEF, dst=7 -> single o_alu_start pulse, then wb addr 7 / data DEADBEEF, PC+=4.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, li instruction retired -> PC wraps to 0. Separately, i_run dropped during DECODE -> instruction retires, then IDLE with o_fetch_req=0.
- With CORE_SEQ_FETCH_TIMEOUT_EN and FETCH_TIMEOUT=16, ack withheld -> TRAP cause 11 after 16 FETCH cycles. Without the macro: still FETCH at cycle 1000. Async reset asserted mid-fetch -> outputs zero immediately, PC=RESET_PC.
